// File: rtl/alu_if.sv
// alu_if: CSR handshake bundle between the FU stage (master) and the ALU responder (slave)
// Ports: OP1/OP2 operands, ALUOP opcode, CSR_ALU_IN {op2 stable, op1 stable, result protect},
//        CSR_ALU_OUT {result valid, op2 ready, op1 ready}, OP3 result.
interface alu_if #(parameter int DBITS = 32);
    logic [DBITS-1:0] OP1;
    logic [DBITS-1:0] OP2;
    logic [DBITS-1:0] OP3;
    logic [3:0]       ALUOP;
    logic [2:0]       CSR_ALU_IN;
    logic [2:0]       CSR_ALU_OUT;
    modport master (output OP1, OP2, ALUOP, CSR_ALU_IN, input CSR_ALU_OUT, OP3);
    modport slave  (input OP1, OP2, ALUOP, CSR_ALU_IN, output CSR_ALU_OUT, OP3);
endinterface

// File: rtl/alu_responder.sv
// alu_responder: ALU endpoint of the three-bit CSR handshake; captures OP1/OP2, executes, publishes OP3
// Ports: clk, reset (sync, active-high), bus (alu_if.slave).
// Optional feature: define ALU_MUL_EN to enable op 10 (MUL, latency MUL_LAT); otherwise op 10 yields 0.
module alu_responder #(
    parameter int DBITS   = 32,
    parameter int ALU_LAT = 2,
    parameter int MUL_LAT = 4
) (
    input logic  clk,
    input logic  reset,
    alu_if.slave bus
);
    localparam int MAX_LAT = ALU_LAT > MUL_LAT ? ALU_LAT : MUL_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    typedef enum logic [2:0] {S_OP1, S_OP2, S_EXEC, S_WRITE, S_VALID} state_t;

    state_t           state_q;
    logic [2:0]       out_q;
    logic [DBITS-1:0] op1_q, op2_q, res_q, op3_q;
    logic [3:0]       aluop_q;
    logic [CW-1:0]    cnt_q;
    logic [DBITS-1:0] res_d;
    logic [CW-1:0]    lat_d;
    logic [4:0]       sh;

    assign sh = op2_q[4:0];

    always_comb begin
        res_d = '0;
        case (aluop_q)
            4'd0:    res_d = op1_q + op2_q;
            4'd1:    res_d = op1_q - op2_q;
            4'd2:    res_d = op1_q & op2_q;
            4'd3:    res_d = op1_q | op2_q;
            4'd4:    res_d = op1_q ^ op2_q;
            4'd5:    res_d = op1_q << sh;
            4'd6:    res_d = op1_q >> sh;
            4'd7:    res_d = DBITS'($signed(op1_q) >>> sh);
            4'd8:    res_d = {{(DBITS-1){1'b0}}, $signed(op1_q) < $signed(op2_q)};
            4'd9:    res_d = {{(DBITS-1){1'b0}}, op1_q < op2_q};
`ifdef ALU_MUL_EN
            4'd10:   res_d = op1_q * op2_q;
`endif
            default: res_d = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    assign lat_d = aluop_q == 4'd10 ? CW'(MUL_LAT) : CW'(ALU_LAT);
`else
    assign lat_d = CW'(ALU_LAT);
`endif

    // Outputs are registered alongside the state so CSR_ALU_OUT always matches the current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_OP1;
            out_q   <= 3'b001;
            op1_q   <= '0;
            op2_q   <= '0;
            aluop_q <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            op3_q   <= '0;
        end else begin
            case (state_q)
                S_OP1: if (bus.CSR_ALU_IN[1]) begin
                    op1_q   <= bus.OP1;
                    aluop_q <= bus.ALUOP;
                    state_q <= S_OP2;
                    out_q   <= 3'b010;
                end
                S_OP2: if (bus.CSR_ALU_IN[2]) begin
                    op2_q   <= bus.OP2;
                    cnt_q   <= lat_d;
                    state_q <= S_EXEC;
                    out_q   <= 3'b000;
                end
                S_EXEC: begin
                    res_q <= res_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) state_q <= S_WRITE;
                end
                S_WRITE: if (!bus.CSR_ALU_IN[0]) begin
                    op3_q   <= res_q;
                    state_q <= S_VALID;
                    out_q   <= 3'b100;
                end
                S_VALID: if (bus.CSR_ALU_IN[0]) begin
                    state_q <= S_OP1;
                    out_q   <= 3'b001;
                end
                default: begin
                    state_q <= S_OP1;
                    out_q   <= 3'b001;
                end
            endcase
        end
    end

    assign bus.CSR_ALU_OUT = out_q;
    assign bus.OP3         = op3_q;
endmodule

// File: tb/tb_alu_responder.sv
// tb_alu_responder: directed vectors for alu_responder checked against a transaction-level model
module tb_alu_responder;
    localparam int ALU_LAT = 2;
    localparam int MUL_LAT = 4;
`ifdef ALU_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;

    alu_if #(.DBITS(32)) bus();

    alu_responder #(.DBITS(32), .ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] s;
        longint unsigned p;
        s = b[4:0];
        p = 64'(a) * 64'(b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a + ~b + 32'd1;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << s;
            4'd6:  return a >> s;
            4'd7:  return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            4'd8:  return {31'b0, (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)};
            4'd9:  return {31'b0, a < b};
            4'd10: return MUL_ON ? p[31:0] : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op);
        return (MUL_ON && op == 4'd10) ? MUL_LAT : ALU_LAT;
    endfunction

    // Model phases: 0 wait OP1, 1 wait OP2, 2 executing, 3 waiting for unprotect, 4 result valid
    int m_phase = 0;
    int m_wait = 0;
    logic [31:0] m_a = 0, m_b = 0, m_op3 = 0;
    logic [3:0] m_op = 0;
    bit started = 1'b0;

    function automatic logic [31:0] exp_out(input int ph);
        return ph == 0 ? 32'd1 : ph == 1 ? 32'd2 : ph == 4 ? 32'd4 : 32'd0;
    endfunction

    always @(posedge clk) begin
        started = 1'b1;
        if (reset) begin
            m_phase = 0;
            m_op3 = 0;
        end else begin
            case (m_phase)
                0: if (bus.CSR_ALU_IN[1]) begin m_a = bus.OP1; m_op = bus.ALUOP; m_phase = 1; end
                1: if (bus.CSR_ALU_IN[2]) begin m_b = bus.OP2; m_wait = ref_lat(m_op); m_phase = 2; end
                2: begin m_wait--; if (m_wait == 0) m_phase = 3; end
                3: if (!bus.CSR_ALU_IN[0]) begin m_op3 = ref_alu(m_op, m_a, m_b); m_phase = 4; end
                default: if (bus.CSR_ALU_IN[0]) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_out", {29'b0, bus.CSR_ALU_OUT}, exp_out(m_phase));
            chk("model_op3", bus.OP3, m_op3);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xact(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
        int k = 0;
        bus.OP1 = a;
        bus.ALUOP = op;
        bus.CSR_ALU_IN = 3'b011;
        cyc(1);
        chk({nm, "_out_op2"}, {29'b0, bus.CSR_ALU_OUT}, 32'd2);
        bus.OP2 = b;
        bus.CSR_ALU_IN = 3'b101;
        cyc(1);
        chk({nm, "_out_exec"}, {29'b0, bus.CSR_ALU_OUT}, 32'd0);
        bus.CSR_ALU_IN = 3'b000;
        while (bus.CSR_ALU_OUT != 3'b100 && k < 40) begin
            cyc(1);
            k++;
        end
        chk({nm, "_lat"}, k, lat + 1);
        chk({nm, "_op3"}, bus.OP3, exp);
        bus.CSR_ALU_IN = 3'b001;
        cyc(1);
        chk({nm, "_out_ack"}, {29'b0, bus.CSR_ALU_OUT}, 32'd1);
        chk({nm, "_op3_held"}, bus.OP3, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.OP1 = 0;
        bus.OP2 = 0;
        bus.ALUOP = 0;
        bus.CSR_ALU_IN = 3'b000;
        cyc(2);
        chk("reset_out", {29'b0, bus.CSR_ALU_OUT}, 32'd1);
        chk("reset_op3", bus.OP3, 32'd0);
        reset = 1'b0;
        cyc(1);
        xact("add", 4'd0, 32'd5, 32'd7, 32'd12, ALU_LAT);
        // protect held long after execution finishes
        bus.OP1 = 32'd9;
        bus.ALUOP = 4'd0;
        bus.CSR_ALU_IN = 3'b011;
        cyc(1);
        bus.OP2 = 32'd6;
        bus.CSR_ALU_IN = 3'b101;
        cyc(1);
        bus.CSR_ALU_IN = 3'b001;
        cyc(10);
        chk("hold_out", {29'b0, bus.CSR_ALU_OUT}, 32'd0);
        chk("hold_op3", bus.OP3, 32'd12);
        bus.CSR_ALU_IN = 3'b000;
        cyc(1);
        chk("hold_rel_out", {29'b0, bus.CSR_ALU_OUT}, 32'd4);
        chk("hold_rel_op3", bus.OP3, 32'd15);
        bus.CSR_ALU_IN = 3'b001;
        cyc(1);
        xact("sub", 4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, ALU_LAT);
        xact("sra", 4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, ALU_LAT);
        xact("slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1, ALU_LAT);
        xact("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, ALU_LAT);
        xact("xor", 4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, ALU_LAT);
        xact("sll33", 4'd5, 32'd1, 32'd33, 32'd2, ALU_LAT);
        xact("srl", 4'd6, 32'h8000_0000, 32'd31, 32'd1, ALU_LAT);
        xact("or", 4'd3, 32'h0F, 32'hF0, 32'hFF, ALU_LAT);
        xact("and", 4'd2, 32'hFF00, 32'h0FF0, 32'h0F00, ALU_LAT);
        xact("addwrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, ALU_LAT);
        xact("mul", 4'd10, 32'h0001_0000, 32'h0001_0003, MUL_ON ? 32'h0003_0000 : 32'd0,
             MUL_ON ? MUL_LAT : ALU_LAT);
        xact("undef13", 4'd13, 32'd5, 32'd7, 32'd0, ALU_LAT);
        // stray handshakes in S_OP1
        bus.CSR_ALU_IN = 3'b100;
        cyc(3);
        chk("stray_op2_out", {29'b0, bus.CSR_ALU_OUT}, 32'd1);
        bus.OP1 = 32'd20;
        bus.OP2 = 32'd99;
        bus.ALUOP = 4'd1;
        bus.CSR_ALU_IN = 3'b110;
        cyc(1);
        chk("both_out", {29'b0, bus.CSR_ALU_OUT}, 32'd2);
        bus.CSR_ALU_IN = 3'b000;
        cyc(2);
        chk("op2_wait_out", {29'b0, bus.CSR_ALU_OUT}, 32'd2);
        bus.OP2 = 32'd3;
        bus.CSR_ALU_IN = 3'b100;
        cyc(1);
        bus.CSR_ALU_IN = 3'b000;
        cyc(ALU_LAT + 1);
        chk("both_res_out", {29'b0, bus.CSR_ALU_OUT}, 32'd4);
        chk("both_res_op3", bus.OP3, 32'd17);
        bus.CSR_ALU_IN = 3'b001;
        cyc(1);
        // reset while a multiply is executing
        bus.OP1 = 32'h0001_0000;
        bus.ALUOP = 4'd10;
        bus.CSR_ALU_IN = 3'b011;
        cyc(1);
        bus.OP2 = 32'h0001_0003;
        bus.CSR_ALU_IN = 3'b101;
        cyc(1);
        bus.CSR_ALU_IN = 3'b001;
        cyc(1);
        reset = 1'b1;
        cyc(1);
        chk("midreset_out", {29'b0, bus.CSR_ALU_OUT}, 32'd1);
        chk("midreset_op3", bus.OP3, 32'd0);
        reset = 1'b0;
        cyc(1);
        xact("add_after_reset", 4'd0, 32'd1, 32'd1, 32'd2, ALU_LAT);
        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_responder.md
# alu_responder

ALU-side endpoint of the three-bit CSR handshake used by the FU stage to offload operations to the external ALU. It accepts OP1 and OP2 through ready/stable handshakes, executes the operation selected by ALUOP over a fixed multi-cycle latency, and writes OP3 only while the initiator leaves the result unprotected. It then raises result-valid until the initiator re-protects the result. It replaces the opaque external ALU model in simulation and synthesis and sits directly under the FU stage.

## Interface
- DBITS, 32, operand/result width
- ALU_LAT, 2, EXEC cycles for non-multiply ops (≥1)
- MUL_LAT, 4, EXEC cycles for MUL (≥1; used only with ALU_MUL_EN)
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- OP1  input  DBITS  first operand, valid while CSR_ALU_IN[1]=1
- OP2  input  DBITS  second operand, valid while CSR_ALU_IN[2]=1
- ALUOP  input  4  operation code, sampled with OP1
- CSR_ALU_IN  input  3  [0] result protect (1 = do not write OP3), [1] OP1 stable, [2] OP2 stable
- CSR_ALU_OUT  output  3  [0] OP1 port ready, [1] OP2 port ready, [2] result valid
- OP3  output  DBITS  result register

## Operation
- Moore FSM: S_OP1 → S_OP2 → S_EXEC → S_WRITE → S_VALID → S_OP1. CSR_ALU_OUT decoded from state only: S_OP1=001, S_OP2=010, S_EXEC/S_WRITE=000, S_VALID=100.
- S_OP1: if IN[1]=1, latch OP1 and ALUOP, go S_OP2. IN[2] ignored, including when it is simultaneous with IN[1].
- S_OP2: if IN[2]=1, latch OP2, load latency counter, go S_EXEC. IN[1] ignored.
- S_EXEC: count down the latency. The result is computed into an internal register. After the LAT-th EXEC cycle, go S_WRITE.
- S_WRITE: if IN[0]=0, load OP3 with the result and go S_VALID. Otherwise hold indefinitely.
- S_VALID: if IN[0]=1 (initiator acknowledge), go S_OP1. OP3 is held unchanged until the next S_WRITE load.
- Ops, all results DBITS wide with wrap-around:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA; shift amount is OP2[4:0]
  - 8 SLT (signed, result 0/1), 9 SLTU (unsigned, result 0/1)
  - 10 MUL: low DBITS of the product
  - 11–15: result 0, latency ALU_LAT
- Latency counter is $clog2(max(ALU_LAT, MUL_LAT)+1) bits wide.

## Timing
- Reset: state=S_OP1, CSR_ALU_OUT=001 during and after reset. OP3=0. Latched operands, ALUOP and counter=0.
- Reset asserted in any state, including mid-EXEC, returns to S_OP1 on the next edge. The pending result is discarded and OP3 is cleared.
- IN[1] high at edge N → CSR_ALU_OUT=010 from cycle N+1. Same rule for IN[2] → 000.
- OP2 capture at edge N → S_WRITE entered at edge N+LAT. Earliest OP3 update at edge N+LAT+1, with CSR_ALU_OUT=100 in the same cycle.
- Multi-cycle stable pulses are harmless: the state has already advanced past the capture state.
- OP3 changes only at the S_WRITE→S_VALID edge and on reset.

## Configuration
- ALU_MUL_EN defined: op 10 computes the DBITS×DBITS low product with latency MUL_LAT.
- ALU_MUL_EN undefined: no multiplier is instantiated. Op 10 behaves as an undefined op: result 0, latency ALU_LAT, and MUL_LAT is ignored.

## Test plan
- ADD: ALUOP=0, OP1=5, OP2=7, IN[0] dropped after OP2 capture → OUT sequence 001→010→000→100; OP3=12 exactly ALU_LAT+1 cycles after OP2 capture. Raising IN[0] → OUT=001, OP3 stays 12.
- SUB/SRA/SLT: SUB 3−5 → 0xFFFFFFFE. SRA 0x80000000 by 4 → 0xF8000000. SLT −1<1 → 1. SLTU with the same operands (0xFFFFFFFF vs 1) → 0.
- Protect hold: keep IN[0]=1 for 10 cycles after EXEC → state stays S_WRITE, OUT=000, OP3 unchanged. IN[0]=0 → OP3 written on the next edge.
- MUL 0x10000×0x10003 → 0x00030000 after MUL_LAT with ALU_MUL_EN defined; → 0 after ALU_LAT without it.
- Stray handshakes: IN[2]=1 in S_OP1 → no state change. IN[1] and IN[2] high together in S_OP1 → only OP1 latched, OUT=010.
- Reset mid-EXEC (MUL in flight) → OUT=001, OP3=0 next cycle; a following ADD 1+1 completes with OP3=2.
